// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell sequenced LSB-first over WIDTH bits with a carry flop.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output `ovf`.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             accept, last;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (c_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // The LSB of the partial-sum shifter would only ever be shifted out, so it is not stored.
  assign s_next = {fa_sum, s_sh};
  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c_q  <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      c_q  <= cin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_next[WIDTH-1:1];
      c_q  <= fa_carry;
      if (last) begin
        cnt  <= '0;
        sum  <= s_next;
        cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= c_q ^ fa_carry;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
